lz77_code_scheduler: RTL and testbench
======================================

// Module: lz77_code_scheduler
// PURPOSE
//  Sequences LZ77 codewords (pos,len,char) into the LZ77 decoder datapath.
//  Buffers codewords from an upstream source in a small FIFO and presents each
//  one to the decoder for exactly len+1 ready beats: len copy beats, then one
//  literal beat. Stops the decoder after the end-of-stream literal.
//  Sits between the testbed/code source and the decoder; owns dec_ready.
// PARAMETERS
//  DEPTH     4     codeword FIFO entries (power of 2, >=2)
//  WINDOW    30    search-buffer size; legal pos range 0..WINDOW-1
//  END_CHAR  8'h24 literal that terminates the stream ('$')
// PORTS
//  clk           in   1   rising-edge clock
//  reset         in   1   asynchronous, active-low reset
//  start         in   1   pulse: begin (IDLE) / re-arm (DONE)
//  in_valid      in   1   codeword valid
//  in_ready      out  1   codeword accepted when in_valid&in_ready
//  in_pos        in   5   match offset into search buffer
//  in_len        in   5   match length (0 = literal only)
//  in_char       in   8   literal following the match
//  dec_ready     out  1   decoder advance strobe (one output char per beat)
//  dec_code_pos  out  5   held pos of current codeword
//  dec_code_len  out  5   held len of current codeword
//  dec_chardata  out  8   held literal of current codeword
//  dec_finish    in   1   decoder finish flag (char_nxt == END_CHAR)
//  busy          out  1   state == RUN
//  done          out  1   one-cycle pulse on entry to DONE
//  err           out  1   sticky: illegal codeword seen; cleared by reset/start
//  char_count    out  16  beats issued since start, saturates at 16'hFFFF
// BEHAVIOUR
//  Reset (reset==0, async): state IDLE, FIFO empty, hold empty, beat=0;
//   all outputs 0 except in_ready=1.
//  States: IDLE -start-> RUN; RUN -terminate-> DONE; DONE -start-> IDLE.
//   start in RUN ignored. Entry to DONE flushes FIFO and hold register.
//  in_ready = !fifo_full && state!=DONE. No pass-through when full.
//   Pushes allowed in IDLE (pre-load) and RUN.
//  Legality: pos>=WINDOW with len!=0 -> err=1; codeword stored with len forced 0.
//  Hold register (pos,len,char,hold_valid) drives dec_code_* directly.
//   Loads from FIFO head in RUN when (!hold_valid || last_beat) && !fifo_empty.
//   Simultaneous push and pop same cycle allowed (count unchanged).
//  dec_ready = (state==RUN) && hold_valid; registered-state-only decode.
//  beat counter 0..len increments on each dec_ready beat; last_beat = beat==len.
//   On last_beat: beat<=0; next codeword loads with no bubble if FIFO non-empty,
//   else hold_valid<=0 and dec_ready drops until a codeword arrives.
//  Latency: push into empty FIFO with empty hold at cycle t -> dec_ready at t+2.
//  Terminate: last_beat && dec_chardata==END_CHAR -> DONE next cycle (that
//   beat is the last one issued); or dec_finish==1 in RUN -> DONE next cycle.
//  char_count cleared on start from IDLE; +1 per dec_ready beat, saturating.
//  done pulses exactly once per DONE entry; busy low in IDLE/DONE.
//  Reset mid-RUN: immediate return to reset values; decoder sees dec_ready=0.
// TESTING
//  1 reset low mid-stream -> dec_ready=0, busy=0, in_ready=1, char_count=0
//    immediately (before next edge).
//  2 preload (0,0,'a'),(3,2,'b'),(0,0,'$'); start -> dec_ready high 1+3+1=5
//    contiguous beats, dec_code_len 0,2,2,2,0; done pulses; char_count=5.
//  3 push DEPTH+1 codewords in IDLE -> in_ready=0 after 4th; 5th held until
//    start and first pop; no codeword lost or duplicated.
//  4 RUN, FIFO drained mid-stream -> dec_ready=0 gap; push (1,1,'x') at t ->
//    dec_ready at t+2 for 2 beats.
//  5 codeword (31,4,'z') -> err=1 sticky, issued as 1 literal beat 'z'.
//  6 dec_finish forced high in RUN -> DONE next cycle, FIFO flushed,
//    in_ready=0; start -> IDLE, in_ready=1, err cleared.

Source files
------------

// File: rtl/lz77_code_scheduler_if.sv
// lz77_code_scheduler_if
//   Groups the codeword source handshake and the decoder-facing signals of
//   the LZ77 code scheduler.
//   Source side : in_valid, in_ready, in_pos, in_len, in_char
//   Decoder side: dec_ready, dec_code_pos, dec_code_len, dec_chardata,
//                 dec_finish
//   slave  - the scheduler (accepts codewords, drives the decoder)
//   master - the environment (code source plus decoder)
interface lz77_code_scheduler_if;
    logic       in_valid;
    logic       in_ready;
    logic [4:0] in_pos;
    logic [4:0] in_len;
    logic [7:0] in_char;
    logic       dec_ready;
    logic [4:0] dec_code_pos;
    logic [4:0] dec_code_len;
    logic [7:0] dec_chardata;
    logic       dec_finish;

    modport slave (
        input  in_valid, in_pos, in_len, in_char, dec_finish,
        output in_ready, dec_ready, dec_code_pos, dec_code_len, dec_chardata
    );

    modport master (
        output in_valid, in_pos, in_len, in_char, dec_finish,
        input  in_ready, dec_ready, dec_code_pos, dec_code_len, dec_chardata
    );
endinterface

// File: rtl/lz77_code_scheduler.sv
// lz77_code_scheduler
//   Buffers LZ77 codewords (pos,len,char) in a small FIFO and presents each
//   one to the decoder for len+1 ready beats (len copy beats, then the
//   literal beat). Stops after the end-of-stream literal or on dec_finish.
// Ports
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   start_i      pulse: IDLE->RUN, DONE->IDLE (ignored in RUN)
//   bus          codeword handshake + decoder interface (slave side)
//   busy_o       high while in RUN
//   done_o       one-cycle pulse on entry to DONE
//   err_o        sticky illegal-codeword flag, cleared by reset/start
//   char_count_o beats issued since start, saturating at 16'hFFFF
//
//   state  | meaning
//   S_IDLE | waiting for start, FIFO may be pre-loaded
//   S_RUN  | issuing decoder beats from the hold register
//   S_DONE | stream finished, FIFO/hold flushed, input blocked
module lz77_code_scheduler #(
    parameter int         DEPTH    = 4,
    parameter int         WINDOW   = 30,
    parameter logic [7:0] END_CHAR = 8'h24
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start_i,
    lz77_code_scheduler_if.slave  bus,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  err_o,
    output logic [15:0]           char_count_o
);

    localparam int          AW       = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
    localparam logic [5:0]  WIN      = 6'(WINDOW);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t state_q, state_d;

    // FIFO word layout: {char[17:10], len[9:5], pos[4:0]}
    logic [17:0]   mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;

    logic [4:0]  hold_pos_q, hold_pos_d;
    logic [4:0]  hold_len_q, hold_len_d;
    logic [7:0]  hold_char_q, hold_char_d;
    logic        hold_valid_q, hold_valid_d;
    logic [4:0]  beat_q, beat_d;
    logic        err_q, err_d;
    logic        done_q, done_d;
    logic [15:0] char_count_q, char_count_d;

    logic        fifo_full, fifo_empty, illegal, push, pop;
    logic        fire, last_beat, terminate, start_ok;
    logic [17:0] push_word, head_word;

    assign fifo_full  = (count_q == FULL_CNT);
    assign fifo_empty = (count_q == '0);
    assign illegal    = ({1'b0, bus.in_pos} >= WIN) && (bus.in_len != 5'd0);
    // Out-of-window matches are kept as plain literals.
    assign push_word  = {bus.in_char, (illegal ? 5'd0 : bus.in_len), bus.in_pos};
    assign head_word  = mem_q[rd_ptr_q];
    assign push       = bus.in_valid && bus.in_ready;
    assign fire       = (state_q == S_RUN) && hold_valid_q;
    assign last_beat  = (beat_q == hold_len_q);
    // Refill on the last beat as well, so back-to-back codewords have no bubble.
    assign pop        = (state_q == S_RUN) && !fifo_empty && (!hold_valid_q || last_beat);
    assign terminate  = (state_q == S_RUN) &&
                        ((fire && last_beat && (hold_char_q == END_CHAR)) || bus.dec_finish);
    assign start_ok   = start_i && (state_q != S_RUN);

    // FSM: state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM: next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start_i)   state_d = S_RUN;
            S_RUN:   if (terminate) state_d = S_DONE;
            S_DONE:  if (start_i)   state_d = S_IDLE;
            default:                state_d = S_IDLE;
        endcase
    end

    // FSM: outputs
    always_comb begin
        bus.in_ready     = !fifo_full && (state_q != S_DONE);
        bus.dec_ready    = fire;
        bus.dec_code_pos = hold_pos_q;
        bus.dec_code_len = hold_len_q;
        bus.dec_chardata = hold_char_q;
        busy_o           = (state_q == S_RUN);
        done_o           = done_q;
        err_o            = err_q;
        char_count_o     = char_count_q;
    end

    // Datapath next-state
    always_comb begin
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        count_d      = count_q;
        hold_pos_d   = hold_pos_q;
        hold_len_d   = hold_len_q;
        hold_char_d  = hold_char_q;
        hold_valid_d = hold_valid_q;
        beat_d       = beat_q;
        err_d        = err_q;
        char_count_d = char_count_q;
        done_d       = terminate;

        if (push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase

        if (fire) beat_d = last_beat ? 5'd0 : beat_q + 1'b1;

        if (pop) begin
            hold_pos_d   = head_word[4:0];
            hold_len_d   = head_word[9:5];
            hold_char_d  = head_word[17:10];
            hold_valid_d = 1'b1;
        end else if (fire && last_beat) begin
            hold_valid_d = 1'b0;
        end

        // Entering DONE discards everything still queued.
        if (terminate) begin
            wr_ptr_d     = '0;
            rd_ptr_d     = '0;
            count_d      = '0;
            hold_pos_d   = '0;
            hold_len_d   = '0;
            hold_char_d  = '0;
            hold_valid_d = 1'b0;
            beat_d       = '0;
        end

        if (push && illegal) begin
            err_d = 1'b1;
        end else if (start_ok) begin
            err_d = 1'b0;
        end

        if ((state_q == S_IDLE) && start_i) begin
            char_count_d = '0;
        end else if (fire && (char_count_q != 16'hFFFF)) begin
            char_count_d = char_count_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            hold_pos_q   <= '0;
            hold_len_q   <= '0;
            hold_char_q  <= '0;
            hold_valid_q <= 1'b0;
            beat_q       <= '0;
            err_q        <= 1'b0;
            done_q       <= 1'b0;
            char_count_q <= '0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            hold_pos_q   <= hold_pos_d;
            hold_len_q   <= hold_len_d;
            hold_char_q  <= hold_char_d;
            hold_valid_q <= hold_valid_d;
            beat_q       <= beat_d;
            err_q        <= err_d;
            done_q       <= done_d;
            char_count_q <= char_count_d;
        end
    end

    // Storage needs no reset: occupancy is tracked by the pointers.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= push_word;
    end

endmodule

// File: tb/tb_lz77_code_scheduler.sv
module tb_lz77_code_scheduler;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        busy, done, err;
    logic [15:0] char_count;

    lz77_code_scheduler_if bus();

    lz77_code_scheduler #(
        .DEPTH(4), .WINDOW(30), .END_CHAR(8'h24)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .start_i(start),
        .bus(bus.slave),
        .busy_o(busy),
        .done_o(done),
        .err_o(err),
        .char_count_o(char_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0] pos;
        logic [4:0] len;
        logic [7:0] chr;
    } beat_t;

    typedef struct {
        logic [4:0] pos;
        logic [4:0] len;
        logic [7:0] chr;
        logic       exp_err;
    } vec_t;

    beat_t      exp_q[$];
    logic [4:0] seen_len[$];
    int         tests = 0;
    int         fails = 0;
    int         cycles = 0;
    int         done_cnt = 0;
    int         beat_cnt = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: actual %0h, expected %0h", name, act, exp);
        end
    endtask

    // Advance to the next falling edge and check any decoder beat there.
    task automatic step();
        beat_t e;
        @(negedge clk);
        cycles++;
        if (cycles > 20000) begin
            fails++;
            $display("FAIL watchdog: cycles %0d exceeded limit 20000", cycles);
            $display("[TB] %0d tests run, %0d failed", tests, fails);
            $fatal(1, "watchdog");
        end
        if (done) done_cnt++;
        if (rst_n && bus.dec_ready) begin
            beat_cnt++;
            seen_len.push_back(bus.dec_code_len);
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected beat: actual pos=%0d len=%0d char=%0h, expected none",
                         bus.dec_code_pos, bus.dec_code_len, bus.dec_chardata);
            end else begin
                e = exp_q.pop_front();
                check("beat", {14'd0, bus.dec_code_pos, bus.dec_code_len, bus.dec_chardata},
                      {14'd0, e.pos, e.len, e.chr});
            end
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    // Called at a falling edge; returns at the falling edge after acceptance.
    task automatic push_cw(input logic [4:0] p, input logic [4:0] l, input logic [7:0] c);
        beat_t      e;
        logic [4:0] leff;
        int         n;
        bus.in_valid = 1'b1;
        bus.in_pos   = p;
        bus.in_len   = l;
        bus.in_char  = c;
        n = 0;
        while (!bus.in_ready && n < 40) begin
            step();
            n++;
        end
        if (!bus.in_ready) begin
            tests++;
            fails++;
            $display("FAIL push timeout: in_ready stayed 0 for %0d cycles, expected 1", n);
            bus.in_valid = 1'b0;
            return;
        end
        leff  = (p >= 5'd30 && l != 5'd0) ? 5'd0 : l;
        e.pos = p;
        e.len = leff;
        e.chr = c;
        for (int i = 0; i <= int'(leff); i++) exp_q.push_back(e);
        step();
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_done(input int bound);
        for (int n = 0; n < bound; n++) begin
            step();
            if (done) return;
        end
        tests++;
        fails++;
        $display("FAIL done timeout: done stayed 0 for %0d cycles, expected 1", bound);
    endtask

    initial begin
        vec_t        tbl[6];
        int          n_hi, first_hi, last_hi, bc;
        logic [24:0] lens_act;
        logic [24:0] lens_exp;

        tbl[0] = '{5'd0,  5'd0,  8'h68, 1'b0};
        tbl[1] = '{5'd29, 5'd3,  8'h69, 1'b0};
        tbl[2] = '{5'd30, 5'd0,  8'h6a, 1'b0};
        tbl[3] = '{5'd30, 5'd1,  8'h6b, 1'b1};
        tbl[4] = '{5'd7,  5'd31, 8'h6c, 1'b1};
        tbl[5] = '{5'd0,  5'd0,  8'h24, 1'b1};

        bus.in_valid   = 1'b0;
        bus.in_pos     = '0;
        bus.in_len     = '0;
        bus.in_char    = '0;
        bus.dec_finish = 1'b0;

        // Reset values
        step();
        step();
        check("rst in_ready", bus.in_ready, 1);
        check("rst dec_ready", bus.dec_ready, 0);
        check("rst busy", busy, 0);
        check("rst done", done, 0);
        check("rst err", err, 0);
        check("rst char_count", char_count, 0);
        check("rst dec_code", {bus.dec_code_pos, bus.dec_code_len, bus.dec_chardata}, 0);
        rst_n = 1'b1;
        step();

        // Preload three codewords, run to the '$' literal
        push_cw(5'd0, 5'd0, 8'h61);
        push_cw(5'd3, 5'd2, 8'h62);
        push_cw(5'd0, 5'd0, 8'h24);
        check("idle busy", busy, 0);
        check("idle dec_ready", bus.dec_ready, 0);
        seen_len.delete();
        done_cnt = 0;
        pulse_start();
        n_hi = 0; first_hi = -1; last_hi = -1;
        for (int cyc = 0; cyc < 30; cyc++) begin
            step();
            if (bus.dec_ready) begin
                n_hi++;
                if (first_hi < 0) first_hi = cyc;
                last_hi = cyc;
            end
            if (done) break;
        end
        check("t2 done", done, 1);
        check("t2 beats", n_hi, 5);
        check("t2 contiguous", last_hi - first_hi + 1, 5);
        lens_act = '0;
        for (int i = 0; i < seen_len.size() && i < 5; i++) lens_act = {lens_act[19:0], seen_len[i]};
        lens_exp = {5'd0, 5'd2, 5'd2, 5'd2, 5'd0};
        check("t2 len seq", lens_act, lens_exp);
        check("t2 char_count", char_count, 5);
        step(); step(); step();
        check("t2 done once", done_cnt, 1);
        check("t2 busy in done", busy, 0);
        check("t2 in_ready in done", bus.in_ready, 0);
        pulse_start();
        check("t2 in_ready idle", bus.in_ready, 1);

        // FIFO full in IDLE, fifth codeword waits for the first pop
        push_cw(5'd1, 5'd1, 8'h63);
        push_cw(5'd2, 5'd0, 8'h64);
        push_cw(5'd0, 5'd3, 8'h65);
        push_cw(5'd4, 5'd1, 8'h66);
        check("t3 full in_ready", bus.in_ready, 0);
        bus.in_valid = 1'b1;
        bus.in_pos   = 5'd0;
        bus.in_len   = 5'd0;
        bus.in_char  = 8'h24;
        step(); step();
        check("t3 still blocked", bus.in_ready, 0);
        pulse_start();
        push_cw(5'd0, 5'd0, 8'h24);
        wait_done(100);
        check("t3 none lost", exp_q.size(), 0);
        check("t3 char_count", char_count, 10);
        pulse_start();

        // Drained FIFO gap, then push-to-beat latency
        pulse_start();
        check("t4 count cleared", char_count, 0);
        push_cw(5'd2, 5'd0, 8'h67);
        step(); step(); step(); step();
        check("t4 gap", bus.dec_ready, 0);
        push_cw(5'd1, 5'd1, 8'h78);
        check("t4 t+1", bus.dec_ready, 0);
        step();
        check("t4 t+2", bus.dec_ready, 1);
        step();
        check("t4 t+3", bus.dec_ready, 1);
        step();
        check("t4 t+4", bus.dec_ready, 0);
        check("t4 char_count", char_count, 3);

        // Illegal codeword becomes a single literal beat, err is sticky
        push_cw(5'd31, 5'd4, 8'h7a);
        check("t5 err set", err, 1);
        step(); step(); step();
        check("t5 err sticky", err, 1);
        check("t5 one beat", exp_q.size(), 0);
        push_cw(5'd0, 5'd0, 8'h24);
        wait_done(50);
        check("t5 err in done", err, 1);
        pulse_start();
        check("t5 err cleared", err, 0);

        // Table-driven stream with window boundary cases
        pulse_start();
        for (int i = 0; i < 6; i++) begin
            push_cw(tbl[i].pos, tbl[i].len, tbl[i].chr);
            check($sformatf("tbl%0d err", i), err, tbl[i].exp_err);
        end
        wait_done(200);
        check("tbl char_count", char_count, 40);
        check("tbl drained", exp_q.size(), 0);
        pulse_start();
        pulse_start();

        // dec_finish forces DONE and flushes queued codewords
        push_cw(5'd5, 5'd6, 8'h6b);
        push_cw(5'd1, 5'd1, 8'h6d);
        push_cw(5'd31, 5'd2, 8'h6e);
        check("t6 err", err, 1);
        check("t6 running", bus.dec_ready, 1);
        bus.dec_finish = 1'b1;
        step();
        bus.dec_finish = 1'b0;
        check("t6 done", done, 1);
        check("t6 busy", busy, 0);
        check("t6 in_ready", bus.in_ready, 0);
        check("t6 dec_ready", bus.dec_ready, 0);
        exp_q.delete();
        pulse_start();
        check("t6 idle in_ready", bus.in_ready, 1);
        check("t6 err cleared", err, 0);
        pulse_start();
        bc = beat_cnt;
        for (int i = 0; i < 6; i++) step();
        check("t6 flushed", beat_cnt - bc, 0);

        // Reset mid-stream takes effect before the next edge
        push_cw(5'd0, 5'd20, 8'h71);
        step(); step(); step();
        check("mid pre dec_ready", bus.dec_ready, 1);
        rst_n = 1'b0;
        #1;
        check("mid rst dec_ready", bus.dec_ready, 0);
        check("mid rst busy", busy, 0);
        check("mid rst in_ready", bus.in_ready, 1);
        check("mid rst char_count", char_count, 0);
        exp_q.delete();
        step();
        rst_n = 1'b1;
        step(); step();
        check("post rst busy", busy, 0);
        check("post rst dec_ready", bus.dec_ready, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
